seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Divides `clk` internally to set the per-digit refresh slot and inserts an anti-ghosting blank gap between digits.
- Double-buffers the displayed value so updates land only at frame boundaries.
- Sits between the board top-level datapath, which presents a 16-bit hex value, and the display pins.

## Interface
- `DIV_BITS`, default 16: width of the slot prescaler; each SHOW slot lasts exactly 2^DIV_BITS cycles.
- `GAP_CYCLES`, default 4: length of the all-anodes-off gap before each digit, in cycles; legal range 1..255.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `value`  in  16  four hex nibbles; nibble k = `value[4k+3:4k]` drives digit k; digit 0 is rightmost.
- `dp`  in  4  decimal point per digit; 1 = lit.
- `load`  in  1  single-cycle strobe that captures `value` and `dp` into the pending buffer.
- `an`  out  4  digit anodes, active-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal-point segment, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary, i.e. when the digit index wraps 3->0.

## Operation
- The FSM has two states, GAP and SHOW, plus a 2-bit digit index `idx`.
- Registers:
  - prescaler: DIV_BITS bits.
  - gap counter: 8 bits.
  - display buffer: 16+4 bits.
  - pending buffer: 16+4 bits, plus a `pend_valid` flag.
- GAP state:
  - `an`=1111, `seg`=1111111, `dp_n`=1.
  - The gap counter increments each cycle.
  - When it reaches GAP_CYCLES-1, the FSM moves to SHOW, the gap counter clears and the prescaler clears.
- SHOW state:
  - `an[idx]`=0 and all other anodes are 1.
  - `seg` = hex decode of display nibble `idx`; `dp_n` = ~display dp[`idx`].
  - The prescaler increments each cycle.
  - When it reaches all-ones, the FSM moves to GAP and `idx` increments modulo 4.
- Hex decode {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Buffering:
  - On `load`=1, the pending buffer is set to {`value`,`dp`} and `pend_valid`=1.
  - Multiple loads before a commit: the last one wins.
- Commit happens on the SHOW->GAP edge where `idx` wraps 3->0. On that edge:
  - `frame_done`=1 for that one cycle.
  - If `pend_valid`=1, the display buffer takes the pending buffer and `pend_valid` clears.
  - If `load` is also high in that same cycle, the live {`value`,`dp`} bypasses directly into the display buffer and `pend_valid` ends at 0.
- `load` during GAP or any other SHOW edge never changes the digit currently lit.

## Timing
- `an`, `seg`, `dp_n` and `frame_done` are registered and change on the same edge as the state transition. There is no combinational path from any input to any output.
- Slot length per digit = GAP_CYCLES + 2^DIV_BITS cycles; frame length = 4 × slot.
- Values at reset assertion:
  - State GAP, `idx`=0, both counters 0.
  - Display buffer 0, pending buffer 0, `pend_valid`=0.
  - `an`=1111, `seg`=1111111, `dp_n`=1, `frame_done`=0.
- Reset is asynchronous: outputs reach these values without waiting for a clock edge.
- After release, the first SHOW (digit 0, showing "0") begins GAP_CYCLES cycles later.
- Reset asserted mid-operation discards the pending buffer and the display buffer.
- `load` latency to the display is 1 to 4 slots. The new value always first appears on digit 0, directly after the commit gap.

## Configuration
- Macro: `SEG_SCAN_LZB_EN` (leading-zero blanking).
- When defined:
  - In SHOW for digit k>0, if display nibbles k..3 are all zero, `an` stays 1111 and `dp_n`=1 for the whole slot.
  - Digit 0 is never blanked.
  - Slot timing, `idx` sequencing and `frame_done` are unchanged.
- When undefined: every digit is lit in its slot, including leading zeros.

## Test plan
Bench parameters: `DIV_BITS`=4, `GAP_CYCLES`=2.
- Reset release:
  - `an`=1111, `seg`=1111111 for 2 cycles.
  - Then `an`=1110, `seg`=1000000 for exactly 16 cycles.
  - Then the gap, then `an`=1101.
- `load` of 16'h12AB with `dp`=0100 mid-frame:
  - No visible change until the 3->0 wrap; `frame_done` pulses there.
  - Next frame: digit 0=0000011, digit 1=0001000, digit 2=0100100 with `dp_n`=0, digit 3=1111001.
- `load` of 16'hF00D in the exact commit cycle: the next frame shows d, 0, 0, F with no one-frame delay, and `pend_valid` is 0 afterwards.
- Two loads (16'h1111, then 16'h2222) before a commit: the next frame shows only 2222.
- With `SEG_SCAN_LZB_EN` and value 16'h0005:
  - Digits 1–3 keep `an`=1111 for their full slots.
  - Digit 0 shows 0010010.
  - Without the macro, digits 1–3 show 1000000.
- `reset` pulled low mid-SHOW of digit 2, between clock edges:
  - Outputs go blank immediately.
  - After release, the display shows 0000 and a previously pending load is lost.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Datapath-to-scan-controller bundle: hex value/dp/load in, display pins and frame pulse out.
interface seg_scan_ctrl_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output value, dp, load,
        input  an, seg, dp_n, frame_done
    );

    modport slave (
        input  value, dp, load,
        output an, seg, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode seven-segment scan controller with blank gaps and frame-aligned commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int unsigned DIV_BITS   = 16,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave disp_if
);

    typedef enum logic [0:0] {StGap, StShow} state_e;

    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [DIV_BITS-1:0]   presc_q, presc_d;
    logic [7:0]            gap_q, gap_d;
    logic [15:0]           disp_val_q, disp_val_d;
    logic [3:0]            disp_dp_q, disp_dp_d;
    logic [15:0]           pend_val_q, pend_val_d;
    logic [3:0]            pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_done_q, frame_done_d;
    logic                  commit;
`ifdef SEG_SCAN_LZB_EN
    logic                  lz_blank;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        presc_d      = presc_q;
        gap_d        = gap_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;

        case (state_q)
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StShow;
                    gap_d   = 8'd0;
                    presc_d = '0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            StShow: begin
                if (presc_q == '1) begin
                    state_d = StGap;
                    idx_d   = idx_q + 2'd1;
                    commit  = (idx_q == 2'd3);
                end else begin
                    presc_d = presc_q + DIV_BITS'(1);
                end
            end
            default: state_d = StGap;
        endcase

        if (disp_if.load) begin
            pend_val_d   = disp_if.value;
            pend_dp_d    = disp_if.dp;
            pend_valid_d = 1'b1;
        end

        // A load coinciding with the commit edge bypasses the pending buffer.
        if (commit) begin
            frame_done_d = 1'b1;
            if (disp_if.load) begin
                disp_val_d   = disp_if.value;
                disp_dp_d    = disp_if.dp;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                disp_val_d   = pend_val_q;
                disp_dp_d    = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end

`ifdef SEG_SCAN_LZB_EN
        lz_blank = ((idx_d == 2'd1) && (disp_val_d[15:4]  == 12'd0)) ||
                   ((idx_d == 2'd2) && (disp_val_d[15:8]  == 8'd0))  ||
                   ((idx_d == 2'd3) && (disp_val_d[15:12] == 4'd0));
`endif

        // Outputs are decoded from next state so they switch with the transition.
        an_d   = 4'b1111;
        seg_d  = 7'b1111111;
        dp_n_d = 1'b1;
        if (state_d == StShow) begin
            an_d        = 4'b1111;
            an_d[idx_d] = 1'b0;
            seg_d       = hex7(disp_val_d[{idx_d, 2'b00} +: 4]);
            dp_n_d      = ~disp_dp_d[idx_d];
`ifdef SEG_SCAN_LZB_EN
            if (lz_blank) begin
                an_d   = 4'b1111;
                dp_n_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StGap;
            idx_q        <= 2'd0;
            presc_q      <= '0;
            gap_q        <= 8'd0;
            disp_val_q   <= 16'd0;
            disp_dp_q    <= 4'd0;
            pend_val_q   <= 16'd0;
            pend_dp_q    <= 4'd0;
            pend_valid_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            presc_q      <= presc_d;
            gap_q        <= gap_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign disp_if.an         = an_q;
    assign disp_if.seg        = seg_q;
    assign disp_if.dp_n       = dp_n_q;
    assign disp_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV_BITS=4, GAP_CYCLES=2 (18-cycle slots, 72-cycle frames).
module tb_seg_scan_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if sif ();

    seg_scan_ctrl #(
        .DIV_BITS   (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .disp_if (sif)
    );

`ifdef SEG_SCAN_LZB_EN
    localparam logic [3:0] LZ = 4'b1110;
`else
    localparam logic [3:0] LZ = 4'b0000;
`endif

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] Sb = 7'b0000011;
    localparam logic [6:0] Sd = 7'b0100001;
    localparam logic [6:0] SF = 7'b0001110;

    // {an, seg, dp_n, frame_done}
    localparam logic [12:0] BLANK = {4'b1111, 7'b1111111, 1'b1, 1'b0};
    localparam logic [12:0] FDGAP = {4'b1111, 7'b1111111, 1'b1, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {sif.an, sif.seg, sif.dp_n, sif.frame_done};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed an/seg/dp_n/fd=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_pend(input string tag);
        n_cmp++;
        assert (dut.pend_valid_q === 1'b0)
        else begin
            n_err++;
            $error("FAIL %s: observed pend_valid=%b expected 0", tag, dut.pend_valid_q);
        end
    endtask

    function automatic logic [12:0] show_exp(input int d, input logic [6:0] s,
                                             input logic dpb, input logic blk);
        logic [3:0] a;
        a = 4'b1111;
        if (!blk) a[d] = 1'b0;
        return {a, s, (blk ? 1'b1 : ~dpb), 1'b0};
    endfunction

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (sif.frame_done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        n_cmp++;
        assert (sif.frame_done === 1'b1)
        else begin
            n_err++;
            $error("FAIL %s: observed no frame_done after %0d cycles expected a pulse", tag, k);
        end
    endtask

    // Starts just after a commit edge; ends on the last SHOW cycle of digit 3.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpv,
                               input logic [3:0] blank,
                               input int la, input logic [15:0] va, input logic [3:0] da,
                               input int lb, input logic [15:0] vb, input logic [3:0] db);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) begin
                tick();
                chk($sformatf("%s gap-a d%0d", tag, d), BLANK);
            end
            tick();
            chk($sformatf("%s gap-b d%0d", tag, d), BLANK);
            tick();
            chk($sformatf("%s first d%0d", tag, d), show_exp(d, segs[7*d +: 7], dpv[d], blank[d]));
            if (d == la) begin
                sif.value = va;
                sif.dp    = da;
                sif.load  = 1'b1;
            end
            if (d == lb) begin
                sif.value = vb;
                sif.dp    = db;
                sif.load  = 1'b1;
            end
            for (int i = 0; i < 15; i++) begin
                tick();
                sif.load = 1'b0;
            end
            chk($sformatf("%s last d%0d", tag, d), show_exp(d, segs[7*d +: 7], dpv[d], blank[d]));
        end
    endtask

    initial begin
        sif.value = 16'h0000;
        sif.dp    = 4'b0000;
        sif.load  = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #2;
        chk("reset async", BLANK);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held", BLANK);
        reset = 1'b1;

        tick();
        chk("rel gap1", BLANK);
        tick();
        chk("rel d0 first", show_exp(0, S0, 1'b0, 1'b0));
        repeat (15) tick();
        chk("rel d0 last", show_exp(0, S0, 1'b0, 1'b0));
        tick();
        chk("rel gap-a d1", BLANK);
        tick();
        chk("rel gap-b d1", BLANK);
        tick();
        chk("rel d1 first", show_exp(1, S0, 1'b0, LZ[1]));

        wait_frame("sync frame");
        // Mid-frame load of 12AB must not show until the next commit.
        check_frame("zero", {S0, S0, S0, S0}, 4'b0000, LZ,
                    1, 16'h12AB, 4'b0100, -1, 16'h0, 4'b0);
        tick();
        chk("commit 12AB fd", FDGAP);
        check_frame("12AB", {S1, S2, SA, Sb}, 4'b0100, 4'b0000,
                    -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

        // Load exactly in the commit cycle: bypass straight to display.
        sif.value = 16'hF00D;
        sif.dp    = 4'b0000;
        sif.load  = 1'b1;
        tick();
        sif.load = 1'b0;
        chk("commit F00D fd", FDGAP);
        chk_pend("bypass pend_valid");
        check_frame("F00D", {SF, S0, S0, Sd}, 4'b0000, 4'b0000,
                    0, 16'h1111, 4'b0001, 2, 16'h2222, 4'b0000);
        tick();
        chk("commit 2222 fd", FDGAP);
        check_frame("2222", {S2, S2, S2, S2}, 4'b0000, 4'b0000,
                    -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

        sif.value = 16'h0005;
        sif.dp    = 4'b0000;
        sif.load  = 1'b1;
        tick();
        sif.load = 1'b0;
        chk("commit 0005 fd", FDGAP);
        check_frame("0005", {S0, S0, S0, S5}, 4'b0000, LZ,
                    -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        tick();
        chk("wrap 0005 fd", FDGAP);

        // Leave 7777 pending, then reset during digit 2.
        tick();
        sif.value = 16'h7777;
        sif.dp    = 4'b1111;
        sif.load  = 1'b1;
        tick();
        sif.load = 1'b0;
        chk("gap load no change", show_exp(0, S5, 1'b0, 1'b0));
        repeat (40) tick();
        chk("pre-reset d2", show_exp(2, S0, 1'b0, LZ[2]));
        #2 reset = 1'b0;
        #1;
        chk("reset mid async", BLANK);
        @(posedge clk);
        #1;
        chk("reset mid held", BLANK);
        chk_pend("reset pend_valid");
        reset = 1'b1;
        tick();
        chk("rel2 gap1", BLANK);
        tick();
        chk("rel2 d0 first", show_exp(0, S0, 1'b0, 1'b0));
        wait_frame("sync frame 2");
        check_frame("post reset", {S0, S0, S0, S0}, 4'b0000, LZ,
                    -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
